// File: rtl/button_value_counter_pkg.sv
// Shared timing and clock-divider constants for the button counter and the display top level.
// All cycle counts assume the 12 MHz board clock.
package button_value_counter_pkg;

    localparam int unsigned CLK_HZ          = 12_000_000;

    localparam int unsigned DEBOUNCE_CYCLES = CLK_HZ / 50;    // 20 ms
    localparam int unsigned HOLD_CYCLES     = CLK_HZ / 2;     // 500 ms
    localparam int unsigned REPEAT_CYCLES   = CLK_HZ / 10;    // 100 ms

    localparam int unsigned DISP_SCAN_HZ    = 1_000;
    localparam int unsigned DISP_SCAN_DIV   = CLK_HZ / DISP_SCAN_HZ;
    localparam int unsigned DISP_DIV_W      = $clog2(DISP_SCAN_DIV);

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_HOLD   = 2'd1,
        R_REPEAT = 2'd2
    } repeat_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus debounce for one raw button; rise pulses one cycle after the level goes high.
// A button held through reset must be seen released before it can produce a rise.
module button_debouncer
    import button_value_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned   CW   = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          sync_1;
    logic          sync_2;
    logic          sync_d;
    logic          level_d;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_cur;
    logic          differ;
    logic          idle_low;
    logic          counting;
    logic          cnt_done;

    always_comb begin
        differ   = sync_2 ^ level;
        // After reset the released state itself must be qualified before presses count.
        idle_low = ~armed & ~sync_2 & ~level;
        counting = differ | idle_low;
        cnt_cur  = (sync_2 != sync_d) ? '0 : cnt;
        cnt_done = (cnt_cur == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            sync_d  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            armed   <= 1'b0;
            rise    <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_1  <= raw;
            sync_2  <= sync_1;
            sync_d  <= sync_2;
            level_d <= level;
            rise    <= level & ~level_d & armed;
            if (counting) begin
                if (cnt_done) begin
                    cnt <= '0;
                    if (differ) begin
                        level <= sync_2;
                    end
                    if (!sync_2) begin
                        armed <= 1'b1;
                    end
                end else begin
                    cnt <= cnt_cur + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/button_value_counter.sv
// Up/down value counter driven by two debounced buttons; pressing one while the other is held clears it.
// Define BUTTON_AUTO_REPEAT_EN to build the hold-to-repeat FSM.
module button_value_counter
    import button_value_counter_pkg::*;
#(
    parameter int          AW       = 8,
    parameter int unsigned DEBOUNCE = DEBOUNCE_CYCLES,
    parameter int unsigned HOLD     = HOLD_CYCLES,
    parameter int unsigned REPEAT   = REPEAT_CYCLES
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          btn_up,
    input  logic          btn_down,
    output logic [AW-1:0] value,
    output logic          step
);

    if (AW < 1 || DEBOUNCE < 1 || HOLD < 1 || REPEAT < 1) begin : g_bad_params
        $error("button_value_counter: AW, DEBOUNCE, HOLD and REPEAT must all be >= 1");
    end

    logic up_lvl;
    logic up_rise;
    logic dn_lvl;
    logic dn_rise;
    logic up_rep;
    logic dn_rep;
    logic up_ev;
    logic dn_ev;
    logic clr;

    button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_up (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_up),
        .level   (up_lvl),
        .rise    (up_rise)
    );

    button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_dn (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_down),
        .level   (dn_lvl),
        .rise    (dn_rise)
    );

`ifdef BUTTON_AUTO_REPEAT_EN
    // state    | meaning
    // R_IDLE   | no button held alone
    // R_HOLD   | one button held alone, waiting HOLD cycles
    // R_REPEAT | one extra event for the held button every REPEAT cycles
    localparam int unsigned TW = cnt_width((HOLD > REPEAT) ? HOLD : REPEAT);

    repeat_state_t state;
    repeat_state_t state_nxt;
    logic          rep_up;
    logic          rep_up_nxt;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nxt;
    logic          held_lvl;
    logic          other_lvl;
    logic          other_rise;
    logic          single_up;
    logic          single_dn;
    logic          tick;

    assign held_lvl   = rep_up ? up_lvl  : dn_lvl;
    assign other_lvl  = rep_up ? dn_lvl  : up_lvl;
    assign other_rise = rep_up ? dn_rise : up_rise;
    assign single_up  = up_rise & ~dn_lvl & ~dn_rise;
    assign single_dn  = dn_rise & ~up_lvl & ~up_rise;
    assign tick       = (tmr == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= R_IDLE;
            rep_up <= 1'b0;
            tmr    <= '0;
        end else begin
            state  <= state_nxt;
            rep_up <= rep_up_nxt;
            tmr    <= tmr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rep_up_nxt = rep_up;
        tmr_nxt    = tmr;
        case (state)
            R_IDLE: begin
                if (single_up || single_dn) begin
                    state_nxt  = R_HOLD;
                    rep_up_nxt = single_up;
                    tmr_nxt    = TW'(HOLD - 1);
                end
            end
            R_HOLD: begin
                if (!held_lvl || other_lvl || other_rise) begin
                    state_nxt = R_IDLE;
                end else if (tick) begin
                    state_nxt = R_REPEAT;
                    tmr_nxt   = TW'(REPEAT - 1);
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            R_REPEAT: begin
                if (!held_lvl || other_lvl || other_rise) begin
                    state_nxt = R_IDLE;
                end else if (tick) begin
                    tmr_nxt = TW'(REPEAT - 1);
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            default: state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        up_rep = 1'b0;
        dn_rep = 1'b0;
        if (state == R_REPEAT && tick && held_lvl && !other_lvl) begin
            up_rep = rep_up;
            dn_rep = ~rep_up;
        end
    end
`else
    assign up_rep = 1'b0;
    assign dn_rep = 1'b0;
`endif

    assign up_ev = up_rise | up_rep;
    assign dn_ev = dn_rise | dn_rep;
    assign clr   = (up_ev & dn_ev) | (up_ev & dn_lvl) | (dn_ev & up_lvl);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
            step  <= 1'b0;
        end else begin
            step <= up_ev | dn_ev;
            if (clr) begin
                value <= '0;
            end else if (up_ev) begin
                value <= value + AW'(1);
            end else if (dn_ev) begin
                value <= value - AW'(1);
            end
        end
    end

endmodule

// File: doc/button_value_counter.md
BUTTON_VALUE_COUNTER -- requirements
Module: button_value_counter

Interface
REQ-001 SHALL have parameter AW, default 8: width of the value output.
REQ-002 SHALL have parameter DEBOUNCE, default 240000: number of stable clk cycles that qualify a button level (20 ms at 12 MHz).
REQ-003 SHALL have parameter HOLD, default 6000000: number of hold cycles before auto-repeat starts (500 ms).
REQ-004 SHALL have parameter REPEAT, default 1200000: number of cycles between auto-repeat steps (100 ms).
REQ-005 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port btn_up, input, 1 bit: raw increment button, active-high, asynchronous to clk.
REQ-008 SHALL have port btn_down, input, 1 bit: raw decrement button, active-high, asynchronous to clk.
REQ-009 SHALL have port value, output, AW bits: registered count that drives the seven-segment decoder addr input.
REQ-010 SHALL have port step, output, 1 bit: registered one-cycle pulse, high in the cycle in which value changes.

Function
REQ-011 SHALL synchronise each raw button through two flip-flops before any other use.
REQ-012 SHALL change a debounced level only after the synchronised input differs from it for DEBOUNCE consecutive cycles; any bounce restarts the count.
REQ-013 SHALL generate a press event one cycle after a debounced level goes 0->1; a 1->0 transition generates no event.
REQ-014 SHALL increment value by 1 on an up event only; AW'hFF..F wraps to 0.
REQ-015 SHALL decrement value by 1 on a down event only; 0 wraps to all-ones.
REQ-016 SHALL clear value to 0 on a press event of either button while the other debounced level is already high; this includes both events in the same cycle.
REQ-017 SHALL set step high in exactly the cycles in which value is written, including a clear from 0 to 0.
REQ-018 SHALL update value and step one clk cycle after the press event (registered).

Reset
REQ-019 SHALL, while reset_n is low, asynchronously force: value=0, step=0, synchronisers=0, debounced levels=0, debounce counters=0, repeat FSM=R_IDLE.
REQ-020 SHALL generate no press event from a button held through reset release until that button has been debounced released and pressed again.

Configuration
REQ-021 SHALL compile auto-repeat logic only when macro BUTTON_AUTO_REPEAT_EN is defined.
REQ-022 SHALL, with BUTTON_AUTO_REPEAT_EN defined, run a repeat FSM:
- R_IDLE -> R_HOLD on a single-button press event.
- R_HOLD -> R_REPEAT after HOLD cycles of that button held alone.
- R_REPEAT: one extra event for the held button every REPEAT cycles.
- Any state -> R_IDLE on release or when the other button is pressed.
REQ-023 SHALL, without BUTTON_AUTO_REPEAT_EN, contain no repeat counters, and a held button SHALL produce exactly one step.

Structure
REQ-024 SHALL place default timing constants (DEBOUNCE, HOLD, REPEAT cycle counts at 12 MHz) in a shared header alongside the clock-divider constants, for use by this block and the display top level.
REQ-025 SHALL implement synchroniser plus debounce as one sub-module, button_debouncer (ports: clk, reset_n, raw, level, rise), instantiated twice.
REQ-026 SHALL size counters with $clog2 of their parameter.

Verification
Run with DEBOUNCE=4, HOLD=16, REPEAT=8, AW=8.
REQ-027 SHALL cover: btn_up held 20 cycles with 2-cycle bounce at the start -> exactly one step, value 0->1.
REQ-028 SHALL cover: value=255, up press -> value 0, step high for 1 cycle; value=0, down press -> 255.
REQ-029 SHALL cover: up held, then down pressed -> value 0, one step, FSM back to R_IDLE.
REQ-030 SHALL cover, with BUTTON_AUTO_REPEAT_EN: up held 60 cycles past debounce -> value 1, then +1 every 8 cycles after 16 hold cycles (value 6).
REQ-031 SHALL cover: reset_n pulsed low mid-repeat with up held -> value 0, step 0 immediately; no step until the button is released and pressed again.
REQ-032 SHALL cover: both buttons pressed in the same cycle -> value 0, single step pulse.
